mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter that shares one single-port synchronous memory between the processor's instruction-fetch port and its load/store data port. It serialises the two requesters with one outstanding access at a time and counts out the memory read latency. It returns read data to the winning requester with a one-cycle valid pulse. It sits between the multicycle core's fetch and MEM stages and a unified instruction/data RAM.

## Interface
- ADDR_W, 32, address width of both requesters and the memory
- DATA_W, 32, data width
- MEM_LATENCY, 1, memory read latency in cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..4
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_gnt  out  1  one-cycle grant pulse for fetch
- if_rvalid  out  1  one-cycle fetch read-data valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  one-cycle grant pulse for data
- d_rvalid  out  1  one-cycle data read-data valid; never asserted for writes
- d_rdata  out  DATA_W  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: with no request, stay. With any request, select a winner per the priority rule, latch its address/we/wdata and a source tag, and go to ISSUE.
- ISSUE, one cycle:
  - mem_en=1 and mem_we/mem_addr/mem_wdata are driven from the latch.
  - The winner's gnt is 1.
  - A write goes to IDLE. A read goes to WAIT with the latency counter loaded with MEM_LATENCY.
- WAIT: decrement the counter each cycle. In the cycle the counter reads 1, capture mem_rdata into the tagged requester's rdata register, then go to RESP.
- RESP, one cycle:
  - The tagged rvalid is 1.
  - If any request is pending, arbitrate exactly as in IDLE and go straight to ISSUE. Otherwise go to IDLE.
- Priority, default: data wins over fetch when both are requesting in the same arbitration cycle.
- Requests arriving while the arbiter is in ISSUE or WAIT are not lost. Requesters hold req, and it is arbitrated at the next IDLE or RESP.
- if_rdata/d_rdata hold their last captured value until overwritten.
- mem_addr/mem_wdata are don't-care when mem_en=0. They are driven to 0 in that case.

## Timing
- Reset values: all gnt/rvalid/mem_en/mem_we = 0, all data/address outputs = 0, state IDLE, counter 0, round-robin pointer = data-first.
- Read latency: a request sampled at edge E puts gnt/mem_en in cycle E+1 and rvalid in cycle E+2+MEM_LATENCY. With MEM_LATENCY=1, rvalid comes 3 cycles after the sampling edge.
- Write: request sampled at edge E puts gnt/mem_en/mem_we in cycle E+1. The earliest next ISSUE is E+3.
- Back-to-back reads: read period is MEM_LATENCY+2 cycles.
- Throughput: never more than one mem_en per 2 cycles.
- gnt and mem_en are always coincident. At most one gnt and at most one rvalid are high in any cycle.
- Reset mid-operation: in any state, rst forces IDLE on the next edge. No rvalid is issued for the aborted access.
- Dropping req before gnt is illegal. If it happens, behaviour is undefined; the bench does not exercise it.

## Configuration
- ARB_ROUND_ROBIN_EN defined: a one-bit pointer selects which port wins a tie, and it flips to the other port after every grant. Back-to-back contention therefore alternates data, fetch, data, ...
- ARB_ROUND_ROBIN_EN undefined: fixed data-over-fetch priority. The pointer register is absent, and fetch can starve while d_req is held.

## Test plan
- Single fetch read, MEM_LATENCY=1: if_req=1, if_addr=0x00400000, mem returns 0x00500093 -> if_gnt and mem_en in cycle 1 with mem_addr=0x00400000; if_rvalid=1 with if_rdata=0x00500093 in cycle 3 only.
- Data write: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> one cycle of mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, d_gnt=1; no d_rvalid.
- Simultaneous reads, both held:
  - Fixed priority: d_gnt first; if_gnt at the following RESP-to-ISSUE, 3 cycles later.
  - ARB_ROUND_ROBIN_EN: with both held for 4 grants, the grant order is D, F, D, F.
- MEM_LATENCY=4 data read at 0x20 returning 0x12345678 -> d_rvalid exactly 6 cycles after the sampling edge; no other rvalid in between.
- rst asserted during WAIT -> next cycle IDLE, all outputs 0, no rvalid. A fresh if_req afterwards is served normally.
- d_req asserted while a fetch is in WAIT -> d_gnt in the RESP+1 cycle; mem_en never asserted twice in consecutive cycles.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory port signals of mem_port_arbiter.
// slave is the arbiter's view; master is the surrounding core + RAM view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store, one access at a time.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {SRC_FETCH, SRC_DATA} src_t;

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  state_t            state, state_nx;
  src_t              tag;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic any_req, arb_slot, arb_take, pick_data, data_first;

  assign any_req   = bus.if_req | bus.d_req;
  assign arb_slot  = (state == IDLE) || (state == RESP);
  assign arb_take  = arb_slot && any_req;
  assign pick_data = bus.d_req && (!bus.if_req || data_first);

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_data_first;

  // Tie-break favours the port that did not win the latest arbitration.
  always_ff @(posedge clk) begin
    if (rst)           rr_data_first <= 1'b1;
    else if (arb_take) rr_data_first <= !pick_data;
  end

  assign data_first = rr_data_first;
`else
  assign data_first = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps all paths assigned and avoids latches.
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = we_q ? IDLE : WAIT;
      WAIT:    if (cnt == 3'd1) state_nx = RESP;
      RESP:    state_nx = any_req ? ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, latency counter and per-port read-data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tag        <= SRC_FETCH;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt        <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (arb_take) begin
        tag     <= pick_data ? SRC_DATA : SRC_FETCH;
        addr_q  <= pick_data ? bus.d_addr : bus.if_addr;
        we_q    <= pick_data && bus.d_we;
        wdata_q <= (pick_data && bus.d_we) ? bus.d_wdata : '0;
      end

      if (state == ISSUE && !we_q) cnt <= LAT;
      else if (state == WAIT)      cnt <= cnt - 3'd1;

      // mem_rdata is valid in the WAIT cycle whose counter reads 1.
      if (state == WAIT && cnt == 3'd1) begin
        if (tag == SRC_DATA) d_rdata_q  <= bus.mem_rdata;
        else                 if_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Outputs decoded from state; gnt and mem_en share the ISSUE cycle by construction.
  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      ISSUE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.if_gnt    = (tag == SRC_FETCH);
        bus.d_gnt     = (tag == SRC_DATA);
      end
      RESP: begin
        bus.if_rvalid = (tag == SRC_FETCH);
        bus.d_rvalid  = (tag == SRC_DATA);
      end
      default: ;
    endcase
  end

  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
endmodule
